// File: rtl/acc_rd_scheduler.sv
// Accumulator read scheduler: walks accumulator rows for every array column,
// either in lock-step (NORMAL) or with one-cycle-per-column systolic skew (DIAG).
module acc_rd_scheduler #(
  parameter int MUL_SIZE = 32,
  parameter int ADDR_W   = 7,
  parameter int CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [ADDR_W-1:0]          base_addr,
  input  logic [CNT_W-1:0]           num_rows,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic [MUL_SIZE-1:0]        rd_en,
  output logic [MUL_SIZE*ADDR_W-1:0] rd_addr
);

  localparam logic             MODE_DIAG = 1'b1;
  localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0] SKEW      = CNT_W'(MUL_SIZE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  k_q, k_d;

  logic [CNT_W-1:0]  n_sat;
  logic [CNT_W-1:0]  issue_len;
  logic [CNT_W-1:0]  last_k;
  logic              issue;
  logic              last_step;

  // DIAG keeps issuing until the last column has drained its n_q rows.
  always_comb begin
    n_sat     = (num_rows > DEPTH) ? DEPTH : num_rows;
    issue_len = (mode_q == MODE_DIAG) ? (n_q + SKEW) : n_q;
    last_k    = issue_len - CNT_W'(1);
    issue     = (state_q == ST_RUN) && out_ready;
    last_step = issue && (k_q == last_k);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    base_d  = base_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          base_d  = base_addr;
          n_d     = n_sat;
          k_d     = '0;
          state_d = (n_sat == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue) begin
          k_d = k_q + CNT_W'(1);
          if (last_step) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      base_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      base_q  <= base_d;
      n_q     <= n_d;
      k_q     <= k_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // Column i sees row offset j = k - i in DIAG; the unsigned compare k >= i guards j < 0.
  for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_col
    localparam logic [CNT_W:0] COL = (CNT_W + 1)'(gi);

    logic [CNT_W:0]    k_ext;
    logic [CNT_W:0]    j_diag;
    logic              active;
    logic [ADDR_W-1:0] offset;

    assign k_ext  = {1'b0, k_q};
    assign j_diag = k_ext - COL;

    always_comb begin
      active = 1'b0;
      offset = '0;
      if (mode_q == MODE_DIAG) begin
        active = (k_ext >= COL) && (j_diag < {1'b0, n_q});
        offset = j_diag[ADDR_W-1:0];
      end else begin
        active = (k_q < n_q);
        offset = k_q[ADDR_W-1:0];
      end
    end

    assign rd_en[gi] = busy & out_ready & active;
    assign rd_addr[gi*ADDR_W +: ADDR_W] = (busy && active) ? (base_q + offset) : '0;
  end

endmodule

// File: tb/tb_acc_rd_scheduler.sv
// Scoreboard bench for acc_rd_scheduler: expected read beats are queued when a
// command is driven and popped whenever the scheduler issues a read.
module tb_acc_rd_scheduler;

  localparam int MUL_SIZE = 32;
  localparam int ADDR_W   = 7;
  localparam int CNT_W    = 8;

  typedef struct packed {
    logic [MUL_SIZE-1:0]        en;
    logic [MUL_SIZE*ADDR_W-1:0] addr;
  } rd_exp_t;

  logic                       clk;
  logic                       rst;
  logic                       start;
  logic                       mode;
  logic [ADDR_W-1:0]          base_addr;
  logic [CNT_W-1:0]           num_rows;
  logic                       out_ready;
  logic                       busy;
  logic                       done;
  logic [MUL_SIZE-1:0]        rd_en;
  logic [MUL_SIZE*ADDR_W-1:0] rd_addr;

  rd_exp_t sbQ[$];

  int errors = 0;
  int checks = 0;
  int cycleNum = 0;
  int readCount;
  int doneCount;
  int busyCount;
  int doneCycle;
  int firstReadCycle;
  int acceptCycle;

  acc_rd_scheduler #(
    .MUL_SIZE(MUL_SIZE),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .base_addr(base_addr),
    .num_rows (num_rows),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: queue one entry per issue step k of the command.
  task automatic pushExpected(input logic m, input int base, input int n);
    int nn;
    int len;
    rd_exp_t e;
    logic [ADDR_W-1:0] a;
    nn  = (n > 128) ? 128 : n;
    len = m ? (nn + MUL_SIZE - 1) : nn;
    for (int k = 0; k < len; k++) begin
      e = '0;
      for (int i = 0; i < MUL_SIZE; i++) begin
        int j;
        j = m ? (k - i) : k;
        if (j >= 0 && j < nn) begin
          a = ADDR_W'((base + j) % 128);
          e.en[i] = 1'b1;
          e.addr[i*ADDR_W +: ADDR_W] = a;
        end
      end
      sbQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic m, input int base, input int n,
                               input bit expectAccept);
    start     = 1'b1;
    mode      = m;
    base_addr = ADDR_W'(base);
    num_rows  = CNT_W'(n);
    if (expectAccept) pushExpected(m, base, n);
  endtask

  task automatic resetCounts();
    readCount      = 0;
    doneCount      = 0;
    busyCount      = 0;
    doneCycle      = -1;
    firstReadCycle = -1;
  endtask

  // One clock: sample on the falling edge, then return just after the rising edge.
  task automatic cycle();
    rd_exp_t e;
    @(negedge clk);
    cycleNum++;
    if (rd_en !== '0) begin
      readCount++;
      if (firstReadCycle < 0) firstReadCycle = cycleNum;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_read", rd_en, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rd_en", rd_en, e.en);
        checkOutput("rd_addr", rd_addr, e.addr);
      end
    end else if (busy !== 1'b1) begin
      checkOutput("idle_addr_zero", rd_addr, 0);
    end
    if (done === 1'b1) begin
      doneCount++;
      doneCycle = cycleNum;
    end
    if (busy === 1'b1) busyCount++;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input int maxCycles);
    for (int c = 0; c < maxCycles && doneCount == 0; c++) cycle();
    checkOutput("done_seen", 256'(doneCount > 0), 1);
  endtask

  task automatic runCmd(input logic m, input int base, input int n);
    resetCounts();
    applyStimulus(m, base, n, 1'b1);
    cycle();
    acceptCycle = cycleNum;
    start = 1'b0;
    waitDone(400);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mode      = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    out_ready = 1'b1;
    #12;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // NORMAL base 10, 4 rows
    runCmd(1'b0, 10, 4);
    checkOutput("t1_first_latency", 256'(firstReadCycle - acceptCycle), 1);
    checkOutput("t1_reads", 256'(readCount), 4);
    checkOutput("t1_done_at", 256'(doneCycle - firstReadCycle), 4);
    checkOutput("t1_sb_empty", 256'(sbQ.size()), 0);
    cycle();
    checkOutput("t1_done_count", 256'(doneCount), 1);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_idle_done", done, 0);

    // DIAG base 127, 2 rows, wrap to 0
    runCmd(1'b1, 127, 2);
    checkOutput("t2_first_latency", 256'(firstReadCycle - acceptCycle), 1);
    checkOutput("t2_reads", 256'(readCount), 33);
    checkOutput("t2_done_at", 256'(doneCycle - firstReadCycle), 33);
    checkOutput("t2_sb_empty", 256'(sbQ.size()), 0);
    cycle();

    // NORMAL base 0, 3 rows, stall at k=1 for 2 cycles
    resetCounts();
    applyStimulus(1'b0, 0, 3, 1'b1);
    cycle();
    start = 1'b0;
    cycle();
    out_ready = 1'b0;
    cycle();
    cycle();
    checkOutput("t3_stall_reads", 256'(readCount), 1);
    checkOutput("t3_stall_en", rd_en, 0);
    checkOutput("t3_stall_busy", busy, 1);
    out_ready = 1'b1;
    #1;
    checkOutput("t3_resume_addr", rd_addr, {32{7'd1}});
    waitDone(50);
    checkOutput("t3_reads", 256'(readCount), 3);
    checkOutput("t3_done_at", 256'(doneCycle - firstReadCycle), 5);
    checkOutput("t3_sb_empty", 256'(sbQ.size()), 0);
    cycle();

    // num_rows = 0: straight to DONE
    resetCounts();
    applyStimulus(1'b0, 5, 0, 1'b1);
    cycle();
    acceptCycle = cycleNum;
    start = 1'b0;
    cycle();
    cycle();
    checkOutput("t4_done_at", 256'(doneCycle - acceptCycle), 1);
    checkOutput("t4_done_count", 256'(doneCount), 1);
    checkOutput("t4_reads", 256'(readCount), 0);
    checkOutput("t4_busy", 256'(busyCount), 0);

    // start during RUN is ignored
    resetCounts();
    applyStimulus(1'b0, 50, 5, 1'b1);
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    applyStimulus(1'b1, 0, 10, 1'b0);
    cycle();
    start = 1'b0;
    waitDone(50);
    for (int c = 0; c < 6; c++) cycle();
    checkOutput("t5_reads", 256'(readCount), 5);
    checkOutput("t5_done_count", 256'(doneCount), 1);
    checkOutput("t5_sb_empty", 256'(sbQ.size()), 0);

    // Reset at DIAG step k=5
    resetCounts();
    applyStimulus(1'b1, 20, 8, 1'b1);
    cycle();
    start = 1'b0;
    for (int c = 0; c < 20 && readCount < 5; c++) cycle();
    checkOutput("t6_pre_rst_en", rd_en, 32'h3F);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_en", rd_en, 0);
    checkOutput("t6_rst_addr", rd_addr, 0);
    checkOutput("t6_rst_busy", busy, 0);
    sbQ.delete();
    resetCounts();
    cycle();
    cycle();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    checkOutput("t6_no_done", 256'(doneCount), 0);
    runCmd(1'b1, 20, 8);
    checkOutput("t6_fresh_latency", 256'(firstReadCycle - acceptCycle), 1);
    checkOutput("t6_fresh_reads", 256'(readCount), 39);
    checkOutput("t6_fresh_sb_empty", 256'(sbQ.size()), 0);
    cycle();

    // num_rows above depth saturates to 128 rows
    runCmd(1'b0, 100, 200);
    checkOutput("t7_reads", 256'(readCount), 128);
    checkOutput("t7_sb_empty", 256'(sbQ.size()), 0);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
